// File: rtl/pipo_load_arbiter.sv
// rtl/pipo_load_arbiter.sv - four-way arbiter that owns and loads a shared WIDTH-bit PIPO register
// Optional build macro PIPO_ARB_FIXED_PRI_EN: fixed priority (requester 0 highest) instead of round-robin.
module pipo_load_arbiter #(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   req_data,
    output logic [3:0]           gnt,
    output logic [WIDTH-1:0]     q,
    output logic                 q_valid,
    output logic [1:0]           owner,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    state_t     state;
    logic [7:0] hold_cnt;
    logic [1:0] win;

`ifdef PIPO_ARB_FIXED_PRI_EN
    // Descending scan so the lowest active index is the last one written.
    always_comb begin
        win = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) begin
                win = 2'(i);
            end
        end
    end
`else
    logic [1:0] ptr;
    logic [1:0] cand;

    // Scan offsets from the far end back to the pointer so the nearest request wins.
    always_comb begin
        win  = ptr;
        cand = ptr;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) begin
                win = cand;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            hold_cnt <= 8'd0;
            gnt      <= 4'd0;
            q        <= '0;
            q_valid  <= 1'b0;
            owner    <= 2'd0;
            busy     <= 1'b0;
`ifndef PIPO_ARB_FIXED_PRI_EN
            ptr      <= 2'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    gnt <= 4'd0;
                    if (|req) begin
                        q       <= req_data[win*WIDTH +: WIDTH];
                        gnt     <= 4'b0001 << win;
                        owner   <= win;
                        q_valid <= 1'b1;
                        busy    <= 1'b1;
`ifndef PIPO_ARB_FIXED_PRI_EN
                        ptr     <= win + 2'd1;
`endif
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    gnt <= 4'd0;
                    if (HOLD_CYCLES == 0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state    <= HOLD;
                        hold_cnt <= HOLD_LOAD;
                    end
                end
                HOLD: begin
                    gnt <= 4'd0;
                    if (hold_cnt == 8'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 4'd0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
